// File: rtl/seq_mult_issue_ctrl.sv
// seq_mult_issue_ctrl: valid/ready front-end that issues operand pairs to a sequential
// multiplier, bypasses zero operands, and flags a multiplier that never completes.
module seq_mult_issue_ctrl #(
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    output logic               mult_start,
    input  logic [2*WIDTH-1:0] mult_product,
    input  logic               mult_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               out_err,
    output logic [CNT_W-1:0]   op_count
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic               mult_start_q, mult_start_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_data_q, out_data_d;
    logic               out_err_q, out_err_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    always_comb begin
        state_d    = state_q;
        mult_a_d   = mult_a_q;
        mult_b_d   = mult_b_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        op_count_d = op_count_q;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mult_a_d = in_a;
                    mult_b_d = in_b;
                    if (in_a == '0 || in_b == '0) begin
                        state_d    = HOLD;
                        out_data_d = '0;
                        out_err_d  = 1'b0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // a done strobe on the watchdog's last cycle still delivers the product
                if (mult_done) begin
                    out_data_d = mult_product;
                    out_err_d  = 1'b0;
                    state_d    = HOLD;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mult_start_d = state_d == ISSUE;
        out_valid_d  = state_d == HOLD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            op_count_q   <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_start_q <= mult_start_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            op_count_q   <= op_count_d;
            wd_q         <= wd_d;
        end
    end

    assign in_ready   = rst && (state_q == IDLE);
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_start = mult_start_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_seq_mult_issue_ctrl.sv
// tb_seq_mult_issue_ctrl: directed stimulus against an edge-counting transaction model,
// with a per-cycle compare process and literal expectations for the key scenarios.
module tb_seq_mult_issue_ctrl;
    localparam int W  = 6;
    localparam int TO = 32;
    localparam int CW = 8;

    logic          clk = 1'b0, rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  in_a = '0, in_b = '0, mult_a, mult_b;
    logic          mult_start, mult_done, out_valid, out_err;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] mult_product, out_data;
    logic [CW-1:0] op_count;

    seq_mult_issue_ctrl #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mult_a(mult_a), .mult_b(mult_b),
        .mult_start(mult_start), .mult_product(mult_product), .mult_done(mult_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Multiplier stand-in: done strobe seen at the edge lat+1 edges after the start edge.
    int lat = 6, cd = -100;
    logic mdone = 1'b0, stray = 1'b0;
    logic [2*W-1:0] mprod = '0;
    assign mult_done    = mdone | stray;
    assign mult_product = mprod;

    initial forever begin
        @(posedge clk);
        #1;
        if (mult_start) begin
            cd    = (lat < 0) ? -100 : lat;
            mprod = (2*W)'(mult_a) * (2*W)'(mult_b);
        end else if (cd >= 0) begin
            cd--;
        end
        mdone = (cd == 0) && !mult_start;
    end

    // Transaction model: one pair in flight, result due at done or start+1+TO edges.
    bit m_busy = 0, m_pend = 0, m_hold = 0, m_start = 0, m_err = 0;
    logic [2*W-1:0] m_data = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [CW-1:0] m_cnt = '0;
    int e = 0, m_st = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 0; m_pend = 0; m_hold = 0; m_start = 0; m_err = 0;
            m_data = '0; m_a = '0; m_b = '0; m_cnt = '0;
        end else begin
            e++;
            m_start = 0;
            if (m_hold) begin
                if (out_ready) begin
                    m_hold = 0; m_busy = 0; m_cnt = m_cnt + 1'b1;
                end
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1; m_a = in_a; m_b = in_b;
                    if (in_a == 0 || in_b == 0) begin
                        m_hold = 1; m_data = '0; m_err = 0;
                    end else begin
                        m_pend = 1; m_st = e; m_start = 1;
                    end
                end
            end else if (m_pend && e >= m_st + 2) begin
                if (mult_done) begin
                    m_pend = 0; m_hold = 1; m_data = mult_product; m_err = 0;
                end else if (e == m_st + 1 + TO) begin
                    m_pend = 0; m_hold = 1; m_data = '0; m_err = 1;
                end
            end
        end
    end

    int cyc = 0, n_start = 0, n_acc = 0, last_start = 0, last_acc = 0, first_valid = 0;
    bit prev_valid = 0;
    logic [2*W-1:0] got_d[$];
    logic got_e[$];

    initial forever begin
        @(negedge clk);
        cyc++;
        chk("in_ready", in_ready, rst && !m_busy);
        chk("mult_start", mult_start, m_start);
        chk("out_valid", out_valid, m_hold);
        chk("op_count", op_count, m_cnt);
        chk("mult_a", mult_a, m_a);
        chk("mult_b", mult_b, m_b);
        if (m_hold) begin
            chk("out_data", out_data, m_data);
            chk("out_err", out_err, m_err);
        end
        if (mult_start) begin n_start++; last_start = cyc; end
        if (in_valid && in_ready) begin n_acc++; last_acc = cyc; end
        if (out_valid && !prev_valid) first_valid = cyc;
        prev_valid = out_valid;
        if (out_valid && out_ready) begin got_d.push_back(out_data); got_e.push_back(out_err); end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int i = 0; i < 200 && !ok; i++) begin ok = in_ready; step(); end
        in_valid = 1'b0;
        chk("accept_bound", ok, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !in_ready; i++) step();
        chk("idle_bound", in_ready, 1);
    endtask

    task automatic chk_last(input string name, input longint d, input longint er);
        chk({name, "_data"}, got_d.size() > 0 ? got_d[got_d.size()-1] : -1, d);
        chk({name, "_err"}, got_e.size() > 0 ? got_e[got_e.size()-1] : -1, er);
    endtask

    int n0, a0, s0;

    initial begin
        step(2);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_op_count", op_count, 0);
        rst = 1'b1;
        step();
        chk("rst_release_in_ready", in_ready, 1);

        // 1: 2x2 through the multiplier, done 6 cycles after start
        n0 = n_start;
        send(2, 2);
        wait_idle();
        chk_last("t1", 4, 0);
        chk("t1_starts", n_start - n0, 1);
        chk("t1_latency", first_valid - last_start, 7);
        chk("t1_count", op_count, 1);

        // 2+5: back-to-back pairs, backpressure with stray done on the last result
        lat = 3; n0 = n_start; a0 = n_acc; s0 = got_d.size();
        send(17, 16);
        send(24, 42);
        send(49, 43);
        out_ready = 1'b0;
        for (int i = 0; i < 100 && !out_valid; i++) step();
        chk("t5_valid_bound", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            stray = (i == 2 || i == 6);
            step();
            chk("t5_hold_data", out_data, 2107);
            chk("t5_hold_ready", in_ready, 0);
        end
        stray = 1'b0;
        chk("t5_count_held", op_count, 3);
        out_ready = 1'b1;
        step();
        chk("t5_in_ready_next", in_ready, 1);
        chk("t2_count", op_count, 4);
        chk("t2_accepts", n_acc - a0, 3);
        chk("t2_starts", n_start - n0, 3);
        chk("t2_results", got_d.size() - s0, 3);
        chk("t2_r0", got_d.size() >= s0 + 3 ? got_d[s0] : -1, 272);
        chk("t2_r1", got_d.size() >= s0 + 3 ? got_d[s0+1] : -1, 1008);
        chk("t2_r2", got_d.size() >= s0 + 3 ? got_d[s0+2] : -1, 2107);

        // 3: zero operand bypass
        n0 = n_start;
        send(0, 37);
        wait_idle();
        chk("t3_starts", n_start - n0, 0);
        chk("t3_latency", first_valid - last_acc, 1);
        chk_last("t3", 0, 0);

        // 4: multiplier never completes, then a normal pair
        lat = -1;
        send(5, 3);
        wait_idle();
        chk("t4_latency", first_valid - last_start, TO + 1);
        chk_last("t4", 0, 1);
        lat = 4;
        send(7, 9);
        wait_idle();
        chk_last("t4_next", 63, 0);

        // 6: reset during WAIT, late done ignored, then wrap of the counter
        lat = 6; n0 = n_start;
        send(11, 13);
        step(3);
        rst = 1'b0;
        #1;
        chk("t6_async_in_ready", in_ready, 0);
        chk("t6_async_mult_a", mult_a, 0);
        chk("t6_async_mult_b", mult_b, 0);
        chk("t6_async_start", mult_start, 0);
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_data", out_data, 0);
        chk("t6_async_err", out_err, 0);
        chk("t6_async_count", op_count, 0);
        step(2);
        rst = 1'b1;
        step(4);
        chk("t6_late_done_valid", out_valid, 0);
        chk("t6_late_done_ready", in_ready, 1);
        chk("t6_no_reissue", n_start - n0, 1);
        lat = 2;
        send(3, 3);
        wait_idle();
        chk_last("t6", 9, 0);
        chk("t6_count", op_count, 1);
        for (int i = 0; i < 255; i++) begin
            send(0, W'(i));
            wait_idle();
        end
        chk("t6_wrap", op_count, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d", passed, checks);
        $fatal(1);
    end
endmodule
